// File: rtl/gat_bram_load_ctrl_if.sv
// ----------------------------------------------------------------------------
// gat_bram_load_ctrl_if
//
// Bundles the host word stream and the four byte-addressed BRAM write ports
// that the GAT input loader drives.
//
//   stream : s_valid, s_data (host -> loader), s_ready (loader -> host)
//   h_data_bram_*      : H data write port       (din/ena/wea/addra)
//   h_node_info_bram_* : node-info write port    (din/ena/wea/addra)
//   wgt_bram_*         : weight write port       (din/ena/wea/addra)
//   subgraph_bram_*    : subgraph-index port     (din/ena/wea/addra)
//
// Modports:
//   master : host / observer side; drives the stream and sees the BRAM ports
//   slave  : loader side; consumes the stream and drives the BRAM ports
// ----------------------------------------------------------------------------
interface gat_bram_load_ctrl_if #(
  parameter int TOP_WIDTH           = 32,
  parameter int H_DATA_ADDR_W       = 18,
  parameter int NODE_INFO_ADDR_W    = 14,
  parameter int WEIGHT_ADDR_W       = 15,
  parameter int SUBGRAPH_IDX_ADDR_W = 14
);

  logic                           s_valid;
  logic [TOP_WIDTH-1:0]           s_data;
  logic                           s_ready;

  logic [TOP_WIDTH-1:0]           h_data_bram_din;
  logic                           h_data_bram_ena;
  logic                           h_data_bram_wea;
  logic [H_DATA_ADDR_W+1:0]       h_data_bram_addra;

  logic [TOP_WIDTH-1:0]           h_node_info_bram_din;
  logic                           h_node_info_bram_ena;
  logic                           h_node_info_bram_wea;
  logic [NODE_INFO_ADDR_W+1:0]    h_node_info_bram_addra;

  logic [TOP_WIDTH-1:0]           wgt_bram_din;
  logic                           wgt_bram_ena;
  logic                           wgt_bram_wea;
  logic [WEIGHT_ADDR_W+1:0]       wgt_bram_addra;

  logic [TOP_WIDTH-1:0]           subgraph_bram_din;
  logic                           subgraph_bram_ena;
  logic                           subgraph_bram_wea;
  logic [SUBGRAPH_IDX_ADDR_W+1:0] subgraph_bram_addra;

  modport master (
    output s_valid, s_data,
    input  s_ready,
    input  h_data_bram_din, h_data_bram_ena, h_data_bram_wea, h_data_bram_addra,
    input  h_node_info_bram_din, h_node_info_bram_ena, h_node_info_bram_wea,
           h_node_info_bram_addra,
    input  wgt_bram_din, wgt_bram_ena, wgt_bram_wea, wgt_bram_addra,
    input  subgraph_bram_din, subgraph_bram_ena, subgraph_bram_wea, subgraph_bram_addra
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready,
    output h_data_bram_din, h_data_bram_ena, h_data_bram_wea, h_data_bram_addra,
    output h_node_info_bram_din, h_node_info_bram_ena, h_node_info_bram_wea,
           h_node_info_bram_addra,
    output wgt_bram_din, wgt_bram_ena, wgt_bram_wea, wgt_bram_addra,
    output subgraph_bram_din, subgraph_bram_ena, subgraph_bram_wea, subgraph_bram_addra
  );

endinterface

// File: rtl/gat_bram_load_ctrl.sv
// ----------------------------------------------------------------------------
// gat_bram_load_ctrl
//
// Loads the four GAT input BRAMs from a single 32-bit valid/ready stream.
// Segments arrive back-to-back in the order H data, H node info, weight,
// subgraph index. Each accepted word is written one cycle later to its BRAM at
// byte address {word_index, 2'b00}. A per-segment load_done level rises one
// cycle after that segment's final write strobe.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start              : pulse; accepted in IDLE/DONE when not busy
//   len_*              : per-segment word counts, sampled at accepted start
//   bus (slave)        : stream in (s_valid/s_data/s_ready) and BRAM write ports
//   *_load_done        : per-segment completion levels
//   busy               : load sequence in progress
//   len_err            : sticky; a sampled length exceeded its BRAM depth
// ----------------------------------------------------------------------------
module gat_bram_load_ctrl #(
  parameter int TOP_WIDTH           = 32,
  parameter int H_DATA_ADDR_W       = 18,
  parameter int NODE_INFO_ADDR_W    = 14,
  parameter int WEIGHT_ADDR_W       = 15,
  parameter int SUBGRAPH_IDX_ADDR_W = 14,
  parameter int LEN_W               = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len_h_data,
  input  logic [LEN_W-1:0]     len_node_info,
  input  logic [LEN_W-1:0]     len_wgt,
  input  logic [LEN_W-1:0]     len_subgraph,
  gat_bram_load_ctrl_if.slave  bus,
  output logic                 h_data_bram_load_done,
  output logic                 h_node_info_bram_load_done,
  output logic                 wgt_bram_load_done,
  output logic                 subgraph_load_done,
  output logic                 busy,
  output logic                 len_err
);

  typedef enum logic [2:0] {
    IDLE, CHECK, LOAD_H, LOAD_NI, LOAD_WGT, LOAD_SG, DONE
  } state_t;

  // BRAM depths in words, one bit wider than the length inputs so a depth of
  // exactly 2^LEN_W would still be representable.
  localparam logic [LEN_W:0] ONE       = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] H_DEPTH   = ONE << H_DATA_ADDR_W;
  localparam logic [LEN_W:0] NI_DEPTH  = ONE << NODE_INFO_ADDR_W;
  localparam logic [LEN_W:0] WGT_DEPTH = ONE << WEIGHT_ADDR_W;
  localparam logic [LEN_W:0] SG_DEPTH  = ONE << SUBGRAPH_IDX_ADDR_W;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_h_q, len_ni_q, len_wgt_q, len_sg_q;
  logic [LEN_W-1:0] word_cnt_q;
  logic [3:0]       done_q;       // {sg, wgt, ni, h}
  logic [3:0]       done_pend_q;  // last write of a segment is on the port now
  logic             busy_q;
  logic             len_err_q;

  logic [LEN_W-1:0] cur_len;
  logic [1:0]       seg;
  logic             in_load;
  logic             s_ready;
  logic             beat;
  logic             seg_last;
  logic             seg_empty;
  logic             seg_adv;
  logic             start_ok;
  logic             len_bad;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake decode
  // --------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cur_len = '0;
    seg     = 2'd0;
    in_load = 1'b0;

    case (state_q)
      LOAD_H:   begin in_load = 1'b1; seg = 2'd0; cur_len = len_h_q;   end
      LOAD_NI:  begin in_load = 1'b1; seg = 2'd1; cur_len = len_ni_q;  end
      LOAD_WGT: begin in_load = 1'b1; seg = 2'd2; cur_len = len_wgt_q; end
      LOAD_SG:  begin in_load = 1'b1; seg = 2'd3; cur_len = len_sg_q;  end
      default:  ;
    endcase

    s_ready   = in_load && (word_cnt_q != cur_len);
    beat      = s_ready && bus.s_valid;
    seg_last  = beat && ((word_cnt_q + LEN_W'(1)) == cur_len);
    // A zero-length segment sits in its state for one cycle, then completes.
    seg_empty = in_load && (cur_len == '0);
    seg_adv   = seg_last || seg_empty;

    // busy stays high one cycle into DONE while the last done flag settles;
    // a start in that cycle is ignored like any other start while busy.
    start_ok  = start && !busy_q && ((state_q == IDLE) || (state_q == DONE));

    len_bad   = ({1'b0, len_h_q}   > H_DEPTH)   ||
                ({1'b0, len_ni_q}  > NI_DEPTH)  ||
                ({1'b0, len_wgt_q} > WGT_DEPTH) ||
                ({1'b0, len_sg_q}  > SG_DEPTH);

    case (state_q)
      IDLE, DONE: if (start_ok) state_d = CHECK;
      CHECK:      state_d = len_bad ? IDLE : LOAD_H;
      LOAD_H:     if (seg_adv) state_d = LOAD_NI;
      LOAD_NI:    if (seg_adv) state_d = LOAD_WGT;
      LOAD_WGT:   if (seg_adv) state_d = LOAD_SG;
      LOAD_SG:    if (seg_adv) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  assign bus.s_ready = s_ready;

  // --------------------------------------------------------------------------
  // Datapath: length capture, word counter, BRAM write ports, status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_h_q                    <= '0;
      len_ni_q                   <= '0;
      len_wgt_q                  <= '0;
      len_sg_q                   <= '0;
      word_cnt_q                 <= '0;
      done_q                     <= '0;
      done_pend_q                <= '0;
      busy_q                     <= 1'b0;
      len_err_q                  <= 1'b0;
      bus.h_data_bram_din        <= '0;
      bus.h_data_bram_ena        <= 1'b0;
      bus.h_data_bram_wea        <= 1'b0;
      bus.h_data_bram_addra      <= '0;
      bus.h_node_info_bram_din   <= '0;
      bus.h_node_info_bram_ena   <= 1'b0;
      bus.h_node_info_bram_wea   <= 1'b0;
      bus.h_node_info_bram_addra <= '0;
      bus.wgt_bram_din           <= '0;
      bus.wgt_bram_ena           <= 1'b0;
      bus.wgt_bram_wea           <= 1'b0;
      bus.wgt_bram_addra         <= '0;
      bus.subgraph_bram_din      <= '0;
      bus.subgraph_bram_ena      <= 1'b0;
      bus.subgraph_bram_wea      <= 1'b0;
      bus.subgraph_bram_addra    <= '0;
    end else begin
      // Strobes are single-cycle; din/addra hold their last written value.
      bus.h_data_bram_ena      <= 1'b0;
      bus.h_data_bram_wea      <= 1'b0;
      bus.h_node_info_bram_ena <= 1'b0;
      bus.h_node_info_bram_wea <= 1'b0;
      bus.wgt_bram_ena         <= 1'b0;
      bus.wgt_bram_wea         <= 1'b0;
      bus.subgraph_bram_ena    <= 1'b0;
      bus.subgraph_bram_wea    <= 1'b0;

      // A segment's done flag follows its final write strobe by one cycle.
      done_pend_q <= '0;
      done_q      <= done_q | done_pend_q;

      if (start_ok) begin
        len_h_q    <= len_h_data;
        len_ni_q   <= len_node_info;
        len_wgt_q  <= len_wgt;
        len_sg_q   <= len_subgraph;
        word_cnt_q <= '0;
        done_q     <= '0;
        len_err_q  <= 1'b0;
        busy_q     <= 1'b1;
      end

      if ((state_q == CHECK) && len_bad) begin
        len_err_q <= 1'b1;
        busy_q    <= 1'b0;
      end

      if (beat) begin
        word_cnt_q <= seg_last ? '0 : word_cnt_q + LEN_W'(1);
        if (seg_last) done_pend_q[seg] <= 1'b1;
        // word_cnt_q < len <= depth, so the truncating casts lose nothing.
        case (seg)
          2'd0: begin
            bus.h_data_bram_din   <= bus.s_data;
            bus.h_data_bram_ena   <= 1'b1;
            bus.h_data_bram_wea   <= 1'b1;
            bus.h_data_bram_addra <= {H_DATA_ADDR_W'(word_cnt_q), 2'b00};
          end
          2'd1: begin
            bus.h_node_info_bram_din   <= bus.s_data;
            bus.h_node_info_bram_ena   <= 1'b1;
            bus.h_node_info_bram_wea   <= 1'b1;
            bus.h_node_info_bram_addra <= {NODE_INFO_ADDR_W'(word_cnt_q), 2'b00};
          end
          2'd2: begin
            bus.wgt_bram_din   <= bus.s_data;
            bus.wgt_bram_ena   <= 1'b1;
            bus.wgt_bram_wea   <= 1'b1;
            bus.wgt_bram_addra <= {WEIGHT_ADDR_W'(word_cnt_q), 2'b00};
          end
          default: begin
            bus.subgraph_bram_din   <= bus.s_data;
            bus.subgraph_bram_ena   <= 1'b1;
            bus.subgraph_bram_wea   <= 1'b1;
            bus.subgraph_bram_addra <= {SUBGRAPH_IDX_ADDR_W'(word_cnt_q), 2'b00};
          end
        endcase
      end

      if (seg_empty) done_q[seg] <= 1'b1;

      // busy drops together with the subgraph done flag.
      if (done_pend_q[3] || (seg_empty && (seg == 2'd3))) busy_q <= 1'b0;
    end
  end

  assign h_data_bram_load_done      = done_q[0];
  assign h_node_info_bram_load_done = done_q[1];
  assign wgt_bram_load_done         = done_q[2];
  assign subgraph_load_done         = done_q[3];
  assign busy                       = busy_q;
  assign len_err                    = len_err_q;

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_gat_bram_load_ctrl
//
// Scoreboard bench: the stream driver pushes the expected BRAM write for every
// beat it sees accepted, and the expected done event for every completed
// segment. A monitor on the falling edge pops and compares whenever a write
// strobe or a rising done flag appears.
// ----------------------------------------------------------------------------
module tb_gat_bram_load_ctrl;

  localparam int LEN_W = 20;

  typedef struct {
    logic [1:0]  seg;
    logic [19:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_exp_t;

  typedef struct {
    logic [1:0] seg;
    int         cyc;
  } done_exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len_h_data, len_node_info, len_wgt, len_subgraph;
  logic             h_done, ni_done, wgt_done, sg_done;
  logic             busy, len_err;
  logic [3:0]       flags;

  gat_bram_load_ctrl_if bus ();

  gat_bram_load_ctrl dut (
    .clk                        (clk),
    .rst                        (rst),
    .start                      (start),
    .len_h_data                 (len_h_data),
    .len_node_info              (len_node_info),
    .len_wgt                    (len_wgt),
    .len_subgraph               (len_subgraph),
    .bus                        (bus),
    .h_data_bram_load_done      (h_done),
    .h_node_info_bram_load_done (ni_done),
    .wgt_bram_load_done         (wgt_done),
    .subgraph_load_done         (sg_done),
    .busy                       (busy),
    .len_err                    (len_err)
  );

  assign flags = {sg_done, wgt_done, ni_done, h_done};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int        n_checks = 0;
  int        n_errors = 0;
  wr_exp_t   exp_wr[$];
  done_exp_t exp_done[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic any_output();
    return |{bus.s_ready, flags, busy, len_err,
             bus.h_data_bram_din, bus.h_data_bram_ena, bus.h_data_bram_wea,
             bus.h_data_bram_addra,
             bus.h_node_info_bram_din, bus.h_node_info_bram_ena,
             bus.h_node_info_bram_wea, bus.h_node_info_bram_addra,
             bus.wgt_bram_din, bus.wgt_bram_ena, bus.wgt_bram_wea, bus.wgt_bram_addra,
             bus.subgraph_bram_din, bus.subgraph_bram_ena, bus.subgraph_bram_wea,
             bus.subgraph_bram_addra};
  endfunction

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic        m_e, m_w;
  logic [31:0] m_d;
  logic [19:0] m_a;
  logic [3:0]  flags_prev = '0;
  logic        busy_prev  = 1'b0;
  wr_exp_t     wx;
  done_exp_t   dx;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        case (i)
          0: begin m_e = bus.h_data_bram_ena; m_w = bus.h_data_bram_wea;
                   m_d = bus.h_data_bram_din; m_a = 20'(bus.h_data_bram_addra); end
          1: begin m_e = bus.h_node_info_bram_ena; m_w = bus.h_node_info_bram_wea;
                   m_d = bus.h_node_info_bram_din; m_a = 20'(bus.h_node_info_bram_addra); end
          2: begin m_e = bus.wgt_bram_ena; m_w = bus.wgt_bram_wea;
                   m_d = bus.wgt_bram_din; m_a = 20'(bus.wgt_bram_addra); end
          default: begin m_e = bus.subgraph_bram_ena; m_w = bus.subgraph_bram_wea;
                   m_d = bus.subgraph_bram_din; m_a = 20'(bus.subgraph_bram_addra); end
        endcase
        if (m_e || m_w) begin
          check("wea_equals_ena", 64'(m_w), 64'(m_e));
          if (exp_wr.size() == 0) begin
            fail_now("unexpected_write", $sformatf("port %0d addr 0x%0h data 0x%0h at cycle %0d",
                                                   i, m_a, m_d, cyc));
          end else begin
            wx = exp_wr.pop_front();
            check("write_seg_addr_data", {i[1:0], m_a, m_d}, {wx.seg, wx.addr, wx.data});
            check("write_cycle", 64'(cyc), 64'(wx.cyc));
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (flags[i] && !flags_prev[i]) begin
          if (exp_done.size() == 0) begin
            fail_now("unexpected_done", $sformatf("flag %0d rose at cycle %0d", i, cyc));
          end else begin
            dx = exp_done.pop_front();
            check("done_seg_cycle", {i[1:0], 32'(cyc)}, {dx.seg, 32'(dx.cyc)});
          end
          if (i == 3) check("busy_falls_with_sg_done", {busy_prev, busy}, 2'b10);
        end
      end
    end
    flags_prev = rst ? 4'b0 : flags;
    busy_prev  = rst ? 1'b0 : busy;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic do_start(input int l[4]);
    @(negedge clk);
    len_h_data    = LEN_W'(l[0]);
    len_node_info = LEN_W'(l[1]);
    len_wgt       = LEN_W'(l[2]);
    len_subgraph  = LEN_W'(l[3]);
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_sets_busy", 64'(busy), 64'd1);
    check("start_clears_flags", 64'(flags), 64'd0);
  endtask

  // Streams words base, base+1, ... across the segments; optional one-cycle
  // idle gap before every odd word; stops early after max_words.
  task automatic stream_words(input int l[4], input logic [31:0] base, input bit gaps,
                              input int max_words);
    int idx = 0;
    int waited;
    int c_pre;
    int e;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < l[s]; k++) begin
        if (idx == max_words) return;
        if (gaps && (idx % 2 == 1)) begin
          @(negedge clk);
          bus.s_valid = 1'b0;
        end
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = base + 32'(idx);
        waited = 0;
        forever begin
          #1;
          if (bus.s_ready) begin
            c_pre = cyc;
            @(posedge clk);
            break;
          end
          if (waited == 50) begin
            fail_now("ready_timeout", $sformatf("word %0d never accepted", idx));
            bus.s_valid = 1'b0;
            return;
          end
          waited++;
          @(negedge clk);
        end
        e = c_pre + 1;
        exp_wr.push_back('{seg: 2'(s), addr: 20'(k * 4), data: base + 32'(idx), cyc: e});
        idx++;
        if (k == l[s] - 1) begin
          exp_done.push_back('{seg: 2'(s), cyc: e + 1});
          for (int d = 1; (s + d < 4) && (l[s + d] == 0); d++)
            exp_done.push_back('{seg: 2'(s + d), cyc: e + d});
          if ((s < 3) && (l[s + 1] == 0)) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            #1;
            check("zero_len_ready_low", 64'(bus.s_ready), 64'd0);
          end
        end
      end
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic poke_start();
    int waited = 0;
    while (!bus.wgt_bram_ena && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.wgt_bram_ena) begin
      fail_now("poke_timeout", "no weight write seen");
      return;
    end
    start         = 1'b1;
    len_h_data    = LEN_W'(7);
    len_node_info = LEN_W'(7);
    len_wgt       = LEN_W'(7);
    len_subgraph  = LEN_W'(7);
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_busy", 64'(busy), 64'd1);
    check("start_ignored_h_done", 64'(h_done), 64'd1);
  endtask

  task automatic run_load(input int l0, input int l1, input int l2, input int l3,
                          input logic [31:0] base, input bit gaps, input bit poke);
    int l[4];
    int waited = 0;
    l = '{l0, l1, l2, l3};
    do_start(l);
    fork
      stream_words(l, base, gaps, 1 << 30);
      if (poke) poke_start();
    join
    while (!sg_done && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!sg_done) begin
      fail_now("done_timeout", "subgraph_load_done never rose");
    end else begin
      repeat (2) @(negedge clk);
      check("write_queue_drained", 64'(exp_wr.size()), 64'd0);
      check("done_queue_drained", 64'(exp_done.size()), 64'd0);
      check("final_flags", 64'(flags), 64'hF);
      check("final_busy", 64'(busy), 64'd0);
      check("final_len_err", 64'(len_err), 64'd0);
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int l[4];
    rst           = 1'b1;
    start         = 1'b0;
    len_h_data    = '0;
    len_node_info = '0;
    len_wgt       = '0;
    len_subgraph  = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", 64'(any_output()), 64'd0);
    rst = 1'b0;

    // A beat offered while idle must stay pending.
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      #1 check("idle_no_ready", 64'(bus.s_ready), 64'd0);
    end
    bus.s_valid = 1'b0;

    // Continuous stream, then the same lengths with gaps (started from DONE).
    run_load(3, 2, 4, 1, 32'hA0, 1'b0, 1'b0);
    run_load(3, 2, 4, 1, 32'hA0, 1'b1, 1'b0);

    // Zero-length node-info segment.
    run_load(2, 0, 2, 2, 32'hC0, 1'b0, 1'b0);

    // Weight length one past depth: error, no writes, flags cleared.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h5555_5555;
    @(negedge clk);
    len_h_data    = LEN_W'(1);
    len_node_info = LEN_W'(1);
    len_wgt       = LEN_W'(32769);
    len_subgraph  = LEN_W'(1);
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_busy_in_check", 64'(busy), 64'd1);
    @(negedge clk);
    check("len_err_set", 64'(len_err), 64'd1);
    check("err_busy_cleared", 64'(busy), 64'd0);
    check("err_flags_zero", 64'(flags), 64'd0);
    repeat (3) @(negedge clk);
    #1 check("err_no_ready", 64'(bus.s_ready), 64'd0);
    check("len_err_sticky", 64'(len_err), 64'd1);
    bus.s_valid = 1'b0;

    // Lengths exactly at depth are legal; abort with reset once loading.
    @(negedge clk);
    len_h_data    = LEN_W'(1);
    len_node_info = LEN_W'(1);
    len_wgt       = LEN_W'(32768);
    len_subgraph  = LEN_W'(16384);
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len_err_cleared_on_start", 64'(len_err), 64'd0);
    @(negedge clk);
    check("depth_len_ok", 64'(len_err), 64'd0);
    check("depth_len_busy", 64'(busy), 64'd1);
    #1 check("depth_len_ready", 64'(bus.s_ready), 64'd1);
    rst = 1'b1;
    #1 check("reset_abort_outputs_zero", 64'(any_output()), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset after 5 of 10 H words; the pending write is dropped.
    l = '{10, 1, 1, 1};
    do_start(l);
    stream_words(l, 32'h10, 1'b0, 5);
    #1;
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    exp_wr.delete();
    exp_done.delete();
    #1 check("reset_mid_load_outputs_zero", 64'(any_output()), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fresh load restarts at address 0.
    run_load(3, 2, 4, 1, 32'hB0, 1'b0, 1'b0);

    // start pulsed during weight loading is ignored.
    run_load(3, 2, 4, 1, 32'h30, 1'b0, 1'b1);

    // Start from DONE with new lengths.
    run_load(2, 1, 1, 2, 32'hE0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gat_bram_load_ctrl.md
Name: gat_bram_load_ctrl

Overview:
Sequences host-side loading of the GAT input BRAMs from one 32-bit valid/ready word stream. Segments are written back-to-back in a fixed order: H data, H node info, weight, subgraph index. For each segment the block drives the byte-addressed BRAM write port of the accelerator top. It raises the per-segment load_done levels that release the accelerator.

Parameters:
TOP_WIDTH, 32, stream and BRAM data word width
H_DATA_ADDR_W, 18, word-address width of H data BRAM
NODE_INFO_ADDR_W, 14, word-address width of node-info BRAM
WEIGHT_ADDR_W, 15, word-address width of weight BRAM
SUBGRAPH_IDX_ADDR_W, 14, word-address width of subgraph BRAM
LEN_W, 20, width of segment length inputs (words)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; begins a load sequence when idle
len_h_data  in  LEN_W  H data word count, sampled at accepted start
len_node_info  in  LEN_W  node-info word count, sampled at start
len_wgt  in  LEN_W  weight word count, sampled at start
len_subgraph  in  LEN_W  subgraph word count, sampled at start
s_valid  in  1  stream word valid
s_data  in  TOP_WIDTH  stream word
s_ready  out  1  stream ready
h_data_bram_din/ena/wea/addra  out  TOP_WIDTH/1/1/H_DATA_ADDR_W+2  H data write port
h_node_info_bram_din/ena/wea/addra  out  TOP_WIDTH/1/1/NODE_INFO_ADDR_W+2  node-info write port
wgt_bram_din/ena/wea/addra  out  TOP_WIDTH/1/1/WEIGHT_ADDR_W+2  weight write port
subgraph_bram_din/ena/wea/addra  out  TOP_WIDTH/1/1/SUBGRAPH_IDX_ADDR_W+2  subgraph write port
h_data_bram_load_done  out  1  H data segment complete (level)
h_node_info_bram_load_done  out  1  node-info segment complete (level)
wgt_bram_load_done  out  1  weight segment complete (level)
subgraph_load_done  out  1  subgraph segment complete (level)
busy  out  1  sequence in progress
len_err  out  1  sticky; a sampled length exceeded its BRAM depth

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE.
- FSM states: IDLE -> CHECK -> LOAD_H -> LOAD_NI -> LOAD_WGT -> LOAD_SG -> DONE. DONE returns to CHECK on start.
- start is accepted only in IDLE or DONE; it is ignored while busy.
- On an accepted start: sample all lengths; clear all load_done flags and len_err; set busy. Go to CHECK for 1 cycle.
- CHECK: if any len > 2^ADDR_W of its BRAM, set len_err, clear busy and go to IDLE. No writes occur. Otherwise go to LOAD_H.
- s_ready = 1 exactly in LOAD_* states whose remaining count is nonzero. A beat is accepted when s_valid && s_ready.
- Write latency is 1 cycle. For a beat accepted at cycle n as the k-th word of the segment (k from 0):
  - at n+1 the segment's port drives din = s_data, ena = wea = 1, addra = {k, 2'b00};
  - all other ports hold ena = wea = 0;
  - addra bits [1:0] are always 0.
- Write strobes stay low in every cycle with no accepted beat; din and addra hold their last value.
- When the last beat of a segment is accepted, the FSM advances to the next state on the same edge. The next segment can accept a beat on the following cycle, so back-to-back streaming has no bubble.
- A segment's load_done rises 1 cycle after its final write strobe, at n+2 relative to the last accepted beat.
- Zero-length segment: the state is held for 1 cycle with s_ready = 0, then load_done rises and the FSM advances.
- DONE: busy = 0. All four flags stay high until the next accepted start or reset.
- Word counters are LEN_W wide, count up from 0, and compare against the sampled length. They never wrap, because CHECK guarantees len ≤ depth.
- Async reset mid-load: the FSM returns to IDLE immediately and all flags, strobes, busy and s_ready clear. A pending write is dropped.
- s_data is never consumed outside LOAD states. An upstream beat held valid while the block is idle stays pending.

Test Plan:
- Lengths 3/2/4/1, stream 0xA0..0xA9 continuous -> H writes addra 0,4,8 with 0xA0..0xA2; NI 0,4; WGT 0,4,8,12; SG 0. Each done rises 2 cycles after its last accept; busy falls with the SG done.
- Same lengths with s_valid toggling every other cycle -> identical addresses and data. No strobe in idle gaps.
- len_node_info = 0, others 2 -> NI done rises 1 cycle after entering LOAD_NI, with no NI strobe and s_ready = 0 that cycle.
- len_wgt = 2^WEIGHT_ADDR_W + 1 -> len_err = 1, busy drops after CHECK, zero writes, flags stay 0.
- Reset asserted after 5 H words of 10 -> all outputs 0 within reset. A fresh start reloads from addra 0.
- start pulsed during LOAD_WGT -> ignored. A second start in DONE clears the flags and reruns with newly sampled lengths.
